// File: rtl/fir_stream_sched_if.sv
// Stream-side and core-side signal bundle for fir_stream_sched.
// slave = scheduler view, master = driver/testbench view.
interface fir_stream_sched_if #(
  parameter int InputWidth  = 16,
  parameter int OutputWidth = 38,
  parameter int CntWidth    = 16
);
  logic                   en;
  logic                   s_valid;
  logic                   s_ready;
  logic [InputWidth-1:0]  s_data;
  logic                   core_in_valid;
  logic [InputWidth-1:0]  core_in_data;
  logic                   core_out_valid;
  logic [OutputWidth-1:0] core_out_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [OutputWidth-1:0] m_data;
  logic                   busy;
  logic                   err;
  logic                   clr_err;
  logic [CntWidth-1:0]    count;

  modport slave (
    input  en, s_valid, s_data, core_out_valid, core_out_data, m_ready, clr_err,
    output s_ready, core_in_valid, core_in_data, m_valid, m_data, busy, err, count
  );

  modport master (
    output en, s_valid, s_data, core_out_valid, core_out_data, m_ready, clr_err,
    input  s_ready, core_in_valid, core_in_data, m_valid, m_data, busy, err, count
  );
endinterface

// File: rtl/fir_stream_sched.sv
// Valid/ready front end for a non-stallable sequential FIR core: input FIFO,
// one-in-flight issue control, held result register and response watchdog.
module fir_stream_sched #(
  parameter int InputWidth    = 16,
  parameter int OutputWidth   = 38,
  parameter int Depth         = 8,
  parameter int TimeoutCycles = 100,
  parameter int CntWidth      = 16
) (
  input  logic              clk,
  input  logic              rst,
  fir_stream_sched_if.slave bus
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [InputWidth-1:0]  mem_q [Depth];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            occ_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [InputWidth-1:0]  cin_data_q;
  logic                   mval_q, mval_d;
  logic [OutputWidth-1:0] mdata_q;
  logic                   err_q, err_d;
  logic [CntWidth-1:0]    cnt_q;

  logic full, empty, push, pop, out_free, capture, timeout, deliver;

  assign full     = (occ_q == (AW+1)'(Depth));
  assign empty    = (occ_q == '0);
  assign push     = bus.s_valid & ~full;
  assign out_free = ~mval_q | bus.m_ready;
  assign deliver  = mval_q & bus.m_ready;

  // Issue is gated on out_free so the core can never overwrite an unread result.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && !empty && out_free) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.core_out_valid) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TW'(TimeoutCycles - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mval_d = capture | (mval_q & ~bus.m_ready);
  assign err_d  = timeout | (err_q & ~bus.clr_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Storage needs no reset; only the pointers/occupancy define contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == AW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cin_data_q <= '0;
      mval_q     <= 1'b0;
      mdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (pop)     cin_data_q <= mem_q[rd_ptr_q];
      if (capture) mdata_q    <= bus.core_out_data;
      if (deliver) cnt_q      <= cnt_q + 1'b1;
      mval_q <= mval_d;
      err_q  <= err_d;
    end
  end

  assign bus.s_ready       = ~full;
  assign bus.core_in_valid = (state_q == ISSUE);
  assign bus.core_in_data  = cin_data_q;
  assign bus.m_valid       = mval_q;
  assign bus.m_data        = mdata_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.err           = err_q;
  assign bus.count         = cnt_q;
endmodule

// File: tb/tb_fir_stream_sched.sv
// Bench for fir_stream_sched: table vectors, directed corner sequences and a
// randomized run against a queue-based reference of FIFO order and core results.
module tb_fir_stream_sched;
  localparam int IW = 16, OW = 38, DEPTH = 8, TO = 100, CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_stream_sched_if #(.InputWidth(IW), .OutputWidth(OW), .CntWidth(CW)) bus();

  fir_stream_sched #(.InputWidth(IW), .OutputWidth(OW), .Depth(DEPTH),
                     .TimeoutCycles(TO), .CntWidth(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference state: samples accepted (in order) and results owed downstream.
  logic [IW-1:0] pushed_q[$];
  logic [OW-1:0] exp_q[$];
  int            tb_deliv = 0;

  // Core model: answers 5*x after a programmable number of cycles.
  logic          cm_ov = 1'b0, spur = 1'b0, cm_never = 1'b0, cm_rand = 1'b0;
  int            cm_lat = 68;
  logic [OW-1:0] cm_od = '0;
  logic          pending = 1'b0;
  int            cdown = 0;
  logic [IW-1:0] cur = '0;

  assign bus.core_out_valid = cm_ov | spur;
  assign bus.core_out_data  = cm_od;

  always @(negedge clk) begin
    cm_ov = 1'b0;
    if (!rst) pending = 1'b0;
    else begin
      if (pending) begin
        cdown--;
        if (cdown == 0) begin
          cm_ov   = 1'b1;
          cm_od   = OW'(cur) * OW'(5);
          exp_q.push_back(OW'(cur) * OW'(5));
          pending = 1'b0;
        end
      end
      if (bus.core_in_valid) begin
        chk("one_in_flight", 64'(pending), 64'(0));
        if (pushed_q.size() == 0) chk("unexpected_issue", 64'(1), 64'(0));
        else begin
          chk("core_in_data_order", 64'(bus.core_in_data), 64'(pushed_q[0]));
          cur = pushed_q.pop_front();
        end
        if (!cm_never) begin
          pending = 1'b1;
          cdown   = cm_rand ? int'($urandom_range(60, TO)) : cm_lat;
        end
      end
    end
  end

  // Downstream monitor: result order/value and hold-while-stalled.
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (prev_stall) begin
        chk("stall_m_valid", 64'(bus.m_valid), 64'(1));
        chk("stall_m_data", 64'(bus.m_data), 64'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
        else chk("m_data", 64'(bus.m_data), 64'(exp_q.pop_front()));
        tb_deliv++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end else prev_stall = 1'b0;
  end

  task automatic push(input logic [IW-1:0] d);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < 5000) begin @(negedge clk); n++; end
    if (!bus.s_ready) chk("push_timeout", 64'(0), 64'(1));
    else pushed_q.push_back(d);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_deliv(input int target, input int limit);
    int n = 0;
    while (tb_deliv < target && n < limit) begin @(negedge clk); n++; end
    chk("deliveries_done", 64'(tb_deliv >= target), 64'(1));
    @(negedge clk);
    chk("count", 64'(bus.count), 64'(CW'(tb_deliv)));
  endtask

  task automatic wait_issue(output int ok);
    int n = 0;
    while (!bus.core_in_valid && n < 300) begin @(negedge clk); n++; end
    ok = int'(bus.core_in_valid);
    chk("issue_seen", 64'(bus.core_in_valid), 64'(1));
  endtask

  typedef struct {
    logic [IW-1:0] d;
    int            lat;
    logic [OW-1:0] exp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ok, j, k, base;
    logic saw;
    bus.en = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.m_ready = 1'b0; bus.clr_err = 1'b0;
    tbl[0] = '{16'h0001, 68,  38'h5};
    tbl[1] = '{16'hFFFF, 66,  38'h4FFFB};
    tbl[2] = '{16'h8000, 70,  38'h28000};
    tbl[3] = '{16'h1234, 67,  38'h5B04};
    tbl[4] = '{16'h0007, TO,  38'h23};   // answer lands on the timeout cycle

    #1;
    chk("rst_core_in_valid", 64'(bus.core_in_valid), 64'(0));
    chk("rst_core_in_data", 64'(bus.core_in_data), 64'(0));
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_m_data", 64'(bus.m_data), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    chk("rst_s_ready", 64'(bus.s_ready), 64'(1));
    bus.en = 1'b1; bus.m_ready = 1'b1;

    // Single-sample vectors: issue latency, result latency, value.
    for (int i = 0; i < 5; i++) begin
      cm_lat = tbl[i].lat;
      bus.s_valid = 1'b1; bus.s_data = tbl[i].d;
      pushed_q.push_back(tbl[i].d);
      @(negedge clk);
      bus.s_valid = 1'b0;
      chk("cin_at_n1", 64'(bus.core_in_valid), 64'(0));
      @(negedge clk);
      chk("cin_at_n2", 64'(bus.core_in_valid), 64'(1));
      chk("cin_data_tbl", 64'(bus.core_in_data), 64'(tbl[i].d));
      @(negedge clk);
      chk("cin_single_pulse", 64'(bus.core_in_valid), 64'(0));
      chk("busy_in_wait", 64'(bus.busy), 64'(1));
      k = 1;
      while (!bus.m_valid && k < 300) begin @(negedge clk); k++; end
      chk("result_latency", 64'(k), 64'(tbl[i].lat + 1));
      chk("m_data_tbl", 64'(bus.m_data), 64'(tbl[i].exp));
      chk("no_err_tbl", 64'(bus.err), 64'(0));
      chk("busy_after", 64'(bus.busy), 64'(0));
      @(negedge clk);
      chk("m_valid_drained", 64'(bus.m_valid), 64'(0));
      chk("count_tbl", 64'(bus.count), 64'(i + 1));
      chk("cin_data_held", 64'(bus.core_in_data), 64'(tbl[i].d));
    end
    cm_lat = 68;

    // Spurious core_out_valid while idle.
    spur = 1'b1; @(negedge clk); spur = 1'b0;
    chk("spur_m_valid", 64'(bus.m_valid), 64'(0));
    @(negedge clk);
    chk("spur_m_valid2", 64'(bus.m_valid), 64'(0));
    chk("spur_err", 64'(bus.err), 64'(0));
    chk("spur_busy", 64'(bus.busy), 64'(0));

    // Fill with en=0, confirm full behaviour, then drain 10 in order.
    base = tb_deliv;
    bus.en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(IW'(16'h0100 + i));
    chk("full_s_ready", 64'(bus.s_ready), 64'(0));
    bus.s_valid = 1'b1; bus.s_data = 16'hDEAD;
    repeat (3) @(negedge clk);
    chk("full_ignored", 64'(bus.s_ready), 64'(0));
    chk("en0_no_issue", 64'(bus.busy), 64'(0));
    bus.s_valid = 1'b0;
    bus.en = 1'b1;
    push(16'h0108); push(16'h0109);
    wait_deliv(base + 10, 3000);

    // Downstream stall keeps the second sample queued.
    base = tb_deliv;
    bus.m_ready = 1'b0;
    push(16'h0AAA); push(16'h0BBB);
    k = 0;
    while (!bus.m_valid && k < 300) begin @(negedge clk); k++; end
    chk("stall_first_data", 64'(bus.m_data), 64'(38'h0AAA * 5));
    saw = 1'b0;
    repeat (150) begin @(negedge clk); saw |= bus.core_in_valid; end
    chk("stall_no_issue", 64'(saw), 64'(0));
    chk("stall_data_held", 64'(bus.m_data), 64'(38'h0AAA * 5));
    bus.m_ready = 1'b1;
    wait_deliv(base + 2, 400);

    // Core never answers: err exactly TO cycles after WAIT entry.
    base = tb_deliv;
    cm_never = 1'b1;
    push(16'h0C0C);
    wait_issue(ok);
    j = 0;
    @(negedge clk); j++;
    cm_never = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 16'h0D0D;
    chk("to_s_ready", 64'(bus.s_ready), 64'(1));
    pushed_q.push_back(16'h0D0D);
    @(negedge clk); j++;
    bus.s_valid = 1'b0;
    while (j < TO) begin @(negedge clk); j++; end
    chk("to_err_before", 64'(bus.err), 64'(0));
    @(negedge clk);
    chk("to_err_set", 64'(bus.err), 64'(1));
    chk("to_idle", 64'(bus.busy), 64'(0));
    chk("to_no_result", 64'(bus.m_valid), 64'(0));
    @(negedge clk);
    chk("to_next_issue", 64'(bus.core_in_valid), 64'(1));
    wait_deliv(base + 1, 300);
    chk("err_sticky", 64'(bus.err), 64'(1));

    // Second timeout with clr_err on the timeout cycle: set wins.
    cm_never = 1'b1;
    push(16'h0E0E);
    wait_issue(ok);
    j = 0;
    @(negedge clk); j++;
    cm_never = 1'b0;
    while (j < TO) begin @(negedge clk); j++; end
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("clr_vs_set", 64'(bus.err), 64'(1));
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("clr_err", 64'(bus.err), 64'(0));

    // Asynchronous reset mid-WAIT with samples queued.
    push(16'h0F01);
    wait_issue(ok);
    push(16'h0F02); push(16'h0F03); push(16'h0F04);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    #3 rst = 1'b0;
    #1;
    chk("arst_core_in_valid", 64'(bus.core_in_valid), 64'(0));
    chk("arst_core_in_data", 64'(bus.core_in_data), 64'(0));
    chk("arst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_count", 64'(bus.count), 64'(0));
    chk("arst_err", 64'(bus.err), 64'(0));
    pushed_q.delete(); exp_q.delete(); tb_deliv = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    chk("arst_s_ready", 64'(bus.s_ready), 64'(1));
    saw = 1'b0;
    repeat (80) begin @(negedge clk); saw |= bus.core_in_valid; end
    chk("arst_no_issue", 64'(saw), 64'(0));
    push(16'h1357);
    wait_issue(ok);
    wait_deliv(1, 300);

    // Randomized traffic, latency, en and m_ready.
    base = tb_deliv;
    cm_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          push(IW'($urandom));
        end
      end
      begin
        int n = 0;
        while (tb_deliv < base + 25 && n < 20000) begin
          @(negedge clk);
          bus.m_ready = ($urandom_range(0, 3) != 0);
          bus.en      = ($urandom_range(0, 7) != 0);
          n++;
        end
        bus.m_ready = 1'b1;
        bus.en      = 1'b1;
      end
    join
    wait_deliv(base + 25, 4000);
    chk("rand_no_err", 64'(bus.err), 64'(0));
    chk("rand_queue_empty", 64'(pushed_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
